// File: rtl/wb_pkg.sv
// Shared write-back types: datapath widths, result source select and request payload.
package wb_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 1 << REG_AW;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_MDU = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous result FIFO for the MDU path (used only when WB_MDU_FIFO_EN is defined).
// Head is visible one cycle after the push that fills an empty FIFO (no fall-through).
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)
(
    input  logic    clk,
    input  logic    rst,
    input  wb_req_t push_req,
    output logic    full_c,
    input  logic    pop,
    output wb_req_t head_c
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned EW = REG_AW + XLEN;

    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [EW-1:0] mem [DEPTH];
    logic          empty;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push_req.valid && !full_c;
    assign do_pop  = pop && !empty;

    // Pointer update; indices wrap naturally modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Payload storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= {push_req.addr, push_req.data};
    end

    // Present the oldest entry.
    always_comb begin
        head_c       = '0;
        head_c.valid = !empty;
        head_c.addr  = mem[rd_ptr[PW-1:0]][EW-1:XLEN];
        head_c.data  = mem[rd_ptr[PW-1:0]][XLEN-1:0];
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back stage: merges ALU, LSU and MDU results onto one register-file write
// port and tracks long-latency destinations in a busy scoreboard for decode.
// Optional macro WB_MDU_FIFO_EN buffers MDU results in wb_result_fifo.
module regfile_writeback
    import wb_pkg::*;
`ifdef WB_MDU_FIFO_EN
#(
    parameter int unsigned MDU_FIFO_DEPTH = 4
)
`endif
(
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_wr_en_i,
    input  logic [REG_AW-1:0]   alu_wr_addr_i,
    input  logic [XLEN-1:0]     alu_wr_data_i,
    input  logic                ld_valid_i,
    output logic                ld_ready_o,
    input  logic [REG_AW-1:0]   ld_addr_i,
    input  logic [XLEN-1:0]     ld_data_i,
    input  logic                md_valid_i,
    output logic                md_ready_o,
    input  logic [REG_AW-1:0]   md_addr_i,
    input  logic [XLEN-1:0]     md_data_i,
    input  logic                sb_set_en_i,
    input  logic [REG_AW-1:0]   sb_set_addr_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                reg_wr_en_o,
    output logic [REG_AW-1:0]   reg_wr_addr_o,
    output logic [XLEN-1:0]     reg_wr_data_o
);

    wb_req_t             ld_req;
    wb_req_t             md_req;
    wb_req_t             md_head;
    wb_req_t             sel_req;
    wb_src_e             sel_src;
    wb_src_e             out_src;
    logic                grant_ld;
    logic                grant_md;
    logic                rr_mdu;
    logic                rr_flip;
    logic [NUM_REGS-1:0] sb_set_mask;
    logic [NUM_REGS-1:0] sb_clr_mask;
    logic [NUM_REGS-1:0] busy_d;

    assign ld_req = '{valid: ld_valid_i, addr: ld_addr_i, data: ld_data_i};
    assign md_req = '{valid: md_valid_i, addr: md_addr_i, data: md_data_i};

`ifdef WB_MDU_FIFO_EN
    logic md_full;

    wb_result_fifo #(.DEPTH(MDU_FIFO_DEPTH)) u_md_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_req (md_req),
        .full_c   (md_full),
        .pop      (grant_md),
        .head_c   (md_head)
    );

    assign md_ready_o = !md_full;
`else
    assign md_head    = md_req;
    assign md_ready_o = grant_md;
`endif

    assign ld_ready_o = grant_ld;

    // Arbitration: ALU always wins; LSU/MDU share the remaining slot round-robin.
    always_comb begin
        grant_ld = 1'b0;
        grant_md = 1'b0;
        rr_flip  = 1'b0;
        sel_req  = '0;
        sel_src  = SRC_ALU;
        if (alu_wr_en_i) begin
            sel_req = '{valid: 1'b1, addr: alu_wr_addr_i, data: alu_wr_data_i};
        end else if (ld_req.valid && md_head.valid) begin
            rr_flip = 1'b1;
            if (rr_mdu) grant_md = 1'b1;
            else        grant_ld = 1'b1;
        end else if (ld_req.valid) begin
            grant_ld = 1'b1;
        end else if (md_head.valid) begin
            grant_md = 1'b1;
        end
        if (grant_ld) begin
            sel_req = ld_req;
            sel_src = SRC_LSU;
        end
        if (grant_md) begin
            sel_req = md_head;
            sel_src = SRC_MDU;
        end
    end

    // Output register and round-robin pointer; x0 writes update addr/data but never enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_wr_en_o   <= 1'b0;
            reg_wr_addr_o <= '0;
            reg_wr_data_o <= '0;
            out_src       <= SRC_ALU;
            rr_mdu        <= 1'b0;
        end else begin
            reg_wr_en_o <= sel_req.valid && (sel_req.addr != '0);
            if (sel_req.valid) begin
                reg_wr_addr_o <= sel_req.addr;
                reg_wr_data_o <= sel_req.data;
                out_src       <= sel_src;
            end
            if (rr_flip) rr_mdu <= !rr_mdu;
        end
    end

    // Scoreboard next state: clear follows the visible LSU/MDU write, set wins, x0 never busy.
    always_comb begin
        sb_set_mask = '0;
        sb_clr_mask = '0;
        if (sb_set_en_i) sb_set_mask[sb_set_addr_i] = 1'b1;
        if (reg_wr_en_o && (out_src != SRC_ALU)) sb_clr_mask[reg_wr_addr_o] = 1'b1;
        busy_d = ((busy_o & ~sb_clr_mask) | sb_set_mask) & ~NUM_REGS'(1);
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_o <= '0;
        else     busy_o <= busy_d;
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback (default build): scoreboard of expected writes,
// queue-driven LSU/MDU sources that hold until accepted, reference busy model.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_wr_en_i = 1'b0;
    logic [4:0]  alu_wr_addr_i = '0;
    logic [31:0] alu_wr_data_i = '0;
    logic        ld_valid_i = 1'b0;
    logic        ld_ready_o;
    logic [4:0]  ld_addr_i = '0;
    logic [31:0] ld_data_i = '0;
    logic        md_valid_i = 1'b0;
    logic        md_ready_o;
    logic [4:0]  md_addr_i = '0;
    logic [31:0] md_data_i = '0;
    logic        sb_set_en_i = 1'b0;
    logic [4:0]  sb_set_addr_i = '0;
    logic [31:0] busy_o;
    logic        reg_wr_en_o;
    logic [4:0]  reg_wr_addr_o;
    logic [31:0] reg_wr_data_o;

    regfile_writeback dut (
        .clk           (clk),
        .rst           (rst),
        .alu_wr_en_i   (alu_wr_en_i),
        .alu_wr_addr_i (alu_wr_addr_i),
        .alu_wr_data_i (alu_wr_data_i),
        .ld_valid_i    (ld_valid_i),
        .ld_ready_o    (ld_ready_o),
        .ld_addr_i     (ld_addr_i),
        .ld_data_i     (ld_data_i),
        .md_valid_i    (md_valid_i),
        .md_ready_o    (md_ready_o),
        .md_addr_i     (md_addr_i),
        .md_data_i     (md_data_i),
        .sb_set_en_i   (sb_set_en_i),
        .sb_set_addr_i (sb_set_addr_i),
        .busy_o        (busy_o),
        .reg_wr_en_o   (reg_wr_en_o),
        .reg_wr_addr_o (reg_wr_addr_o),
        .reg_wr_data_o (reg_wr_data_o)
    );

    always #5 clk = ~clk;

    localparam int G_NONE = 0;
    localparam int G_ALU  = 1;
    localparam int G_LSU  = 2;
    localparam int G_MDU  = 3;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        int          src;
    } exp_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } req_t;

    exp_t        exp_q[$];
    req_t        ld_q[$];
    req_t        md_q[$];
    logic [31:0] wr_log[$];

    logic [31:0] m_busy;
    logic        m_rr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_idle();
        exp_t e;
        e.en = 1'b0; e.addr = m_addr; e.data = m_data; e.src = G_NONE;
        exp_q.push_back(e);
    endtask

    // One clock cycle: drive sources, check previous write and busy, model this cycle.
    task automatic step();
        exp_t        e;
        exp_t        n;
        int          g;
        logic [31:0] clr;
        logic [31:0] set;
        ld_valid_i = (ld_q.size() > 0);
        ld_addr_i  = ld_valid_i ? ld_q[0].addr : 5'd0;
        ld_data_i  = ld_valid_i ? ld_q[0].data : 32'd0;
        md_valid_i = (md_q.size() > 0);
        md_addr_i  = md_valid_i ? md_q[0].addr : 5'd0;
        md_data_i  = md_valid_i ? md_q[0].data : 32'd0;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("exp_underflow", 32'd1, 32'd0);
            e.en = 1'b0; e.addr = m_addr; e.data = m_data; e.src = G_NONE;
        end else begin
            e = exp_q.pop_front();
        end
        chk("wr_en",   32'(reg_wr_en_o), 32'(e.en));
        chk("wr_addr", 32'(reg_wr_addr_o), 32'(e.addr));
        chk("wr_data", reg_wr_data_o, e.data);
        chk("busy",    busy_o, m_busy);
        if (reg_wr_en_o) wr_log.push_back(reg_wr_data_o);

        if (alu_wr_en_i)                   g = G_ALU;
        else if (ld_valid_i && md_valid_i) begin g = m_rr ? G_MDU : G_LSU; m_rr = !m_rr; end
        else if (ld_valid_i)               g = G_LSU;
        else if (md_valid_i)               g = G_MDU;
        else                               g = G_NONE;
        chk("ld_ready", 32'(ld_ready_o), 32'(g == G_LSU));
        chk("md_ready", 32'(md_ready_o), 32'(g == G_MDU));

        if (g == G_NONE) begin
            push_idle();
        end else begin
            n.src  = g;
            n.addr = (g == G_ALU) ? alu_wr_addr_i : (g == G_LSU) ? ld_addr_i : md_addr_i;
            n.data = (g == G_ALU) ? alu_wr_data_i : (g == G_LSU) ? ld_data_i : md_data_i;
            n.en   = (n.addr != 5'd0);
            m_addr = n.addr;
            m_data = n.data;
            exp_q.push_back(n);
        end

        clr = '0;
        set = '0;
        if (e.en && (e.src == G_LSU || e.src == G_MDU)) clr[e.addr] = 1'b1;
        if (sb_set_en_i && sb_set_addr_i != 5'd0) set[sb_set_addr_i] = 1'b1;
        m_busy = (m_busy & ~clr) | set;

        @(posedge clk);
        #1;
        if (g == G_LSU) void'(ld_q.pop_front());
        if (g == G_MDU) void'(md_q.pop_front());
        alu_wr_en_i = 1'b0;
        sb_set_en_i = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_busy",    busy_o, 32'd0);
        chk("rst_wr_en",   32'(reg_wr_en_o), 32'd0);
        chk("rst_wr_addr", 32'(reg_wr_addr_o), 32'd0);
        chk("rst_wr_data", reg_wr_data_o, 32'd0);
        exp_q.delete(); ld_q.delete(); md_q.delete(); wr_log.delete();
        m_busy = '0; m_rr = 1'b0; m_addr = '0; m_data = '0;
        alu_wr_en_i = 1'b0; sb_set_en_i = 1'b0;
        ld_valid_i = 1'b0; md_valid_i = 1'b0;
        push_idle();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && (ld_q.size() > 0 || md_q.size() > 0); i++) step();
        chk("drain_timeout", 32'(ld_q.size() + md_q.size()), 32'd0);
        step();
        step();
    endtask

    task automatic push_ld(input logic [4:0] a, input logic [31:0] d);
        req_t r;
        r.addr = a; r.data = d;
        ld_q.push_back(r);
    endtask

    task automatic push_md(input logic [4:0] a, input logic [31:0] d);
        req_t r;
        r.addr = a; r.data = d;
        md_q.push_back(r);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        step();

        // ALU and LSU collide: ALU first, LSU next cycle.
        push_ld(5'd6, 32'hCAFE_0006);
        alu_wr_en_i = 1'b1; alu_wr_addr_i = 5'd5; alu_wr_data_i = 32'hDEAD_BEEF;
        step();
        chk("alu_x5_en",   32'(reg_wr_en_o), 32'd1);
        chk("alu_x5_data", reg_wr_data_o, 32'hDEAD_BEEF);
        step();
        chk("lsu_x6_addr", 32'(reg_wr_addr_o), 32'd6);
        chk("lsu_x6_data", reg_wr_data_o, 32'hCAFE_0006);
        step();

        // LSU and MDU continuously valid: strict alternation starting with LSU.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_ld(5'(10 + i), 32'h100 + 32'(i));
            push_md(5'(20 + i), 32'h200 + 32'(i));
        end
        drain(20);
        chk("alt_count", 32'(wr_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < wr_log.size(); i++)
            chk("alt_order", wr_log[i], ((i % 2) == 0 ? 32'h100 : 32'h200) + 32'(i / 2));

        // Scoreboard set, clear one cycle after the write, set-wins collision.
        sb_set_en_i = 1'b1; sb_set_addr_i = 5'd7;
        step();
        step();
        chk("busy7_set", 32'(busy_o[7]), 32'd1);
        push_ld(5'd7, 32'h0000_1234);
        step();
        chk("x7_wr_addr", 32'(reg_wr_addr_o), 32'd7);
        chk("busy7_hold", 32'(busy_o[7]), 32'd1);
        step();
        chk("busy7_clr", 32'(busy_o[7]), 32'd0);
        sb_set_en_i = 1'b1; sb_set_addr_i = 5'd7;
        step();
        push_ld(5'd7, 32'h0000_5678);
        step();
        sb_set_en_i = 1'b1; sb_set_addr_i = 5'd7;
        step();
        chk("busy7_setwins", 32'(busy_o[7]), 32'd1);
        step();

        // Writes and scoreboard sets targeting x0.
        alu_wr_en_i = 1'b1; alu_wr_addr_i = 5'd0; alu_wr_data_i = 32'hFFFF_FFFF;
        sb_set_en_i = 1'b1; sb_set_addr_i = 5'd0;
        step();
        chk("x0_wr_en",   32'(reg_wr_en_o), 32'd0);
        chk("x0_wr_data", reg_wr_data_o, 32'hFFFF_FFFF);
        step();
        chk("x0_busy", 32'(busy_o[0]), 32'd0);

        // Randomised mix with hold-until-accepted sources.
        for (int c = 0; c < 60; c++) begin
            if (ld_q.size() < 3 && $urandom_range(0, 1) == 1)
                push_ld(5'($urandom_range(0, 31)), $urandom);
            if (md_q.size() < 3 && $urandom_range(0, 2) == 0)
                push_md(5'($urandom_range(0, 31)), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                alu_wr_en_i = 1'b1;
                alu_wr_addr_i = 5'($urandom_range(0, 31));
                alu_wr_data_i = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
                sb_set_en_i = 1'b1;
                sb_set_addr_i = 5'($urandom_range(0, 31));
            end
            step();
        end
        drain(40);

        // Reset mid-stream with busy bits and a pending MDU result.
        do_reset();
        sb_set_en_i = 1'b1; sb_set_addr_i = 5'd2;
        step();
        sb_set_en_i = 1'b1; sb_set_addr_i = 5'd5;
        step();
        push_md(5'd9, 32'h0000_ABCD);
        alu_wr_en_i = 1'b1; alu_wr_addr_i = 5'd3; alu_wr_data_i = 32'h33;
        step();
        chk("pre_rst_busy",  busy_o, 32'h0000_0024);
        chk("pre_rst_wr_en", 32'(reg_wr_en_o), 32'd1);
        do_reset();
        for (int i = 0; i < 4; i++) step();
        chk("post_rst_writes", 32'(wr_log.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-back stage: the register-file writer that pairs with the decode stage's register-file reads.
- Merges results from the single-cycle ALU, the load unit (LSU) and the multiply/divide unit (MDU) into one register-file write port per cycle.
- Keeps a 32-entry scoreboard of registers with long-latency results outstanding; decode stalls on it.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.
- MDU_FIFO_DEPTH, 4, MDU result buffer entries (power of 2, ≥2); used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- alu_wr_en_i  in  1  ALU result valid; no backpressure
- alu_wr_addr_i  in  REG_AW  ALU destination
- alu_wr_data_i  in  XLEN  ALU result
- ld_valid_i  in  1  load result valid
- ld_ready_o  out  1  load result accepted
- ld_addr_i  in  REG_AW  load destination
- ld_data_i  in  XLEN  load data
- md_valid_i  in  1  MDU result valid
- md_ready_o  out  1  MDU result accepted
- md_addr_i  in  REG_AW  MDU destination
- md_data_i  in  XLEN  MDU result
- sb_set_en_i  in  1  decode issued a load/mul/div
- sb_set_addr_i  in  REG_AW  its rd
- busy_o  out  32  scoreboard, bit n = xn pending
- reg_wr_en_o  out  1  register-file write enable
- reg_wr_addr_o  out  REG_AW  write address
- reg_wr_data_o  out  XLEN  write data

Behaviour:
- Single clock; rst asynchronous, active-high.
- Reset values: reg_wr_en_o=0, reg_wr_addr_o=0, reg_wr_data_o=0, busy_o=0. The RR pointer selects LSU. The FIFO is empty.
- Reset mid-operation discards all pending results and scoreboard state.
- Output stage is registered. A result accepted in cycle N appears on reg_wr_* in cycle N+1, for exactly one cycle.
- Arbitration per cycle:
  - The ALU always wins.
  - When alu_wr_en_i=1, ld_ready_o=0 and md_ready_o=0 (MDU path without the optional feature).
  - Otherwise LSU and MDU are round-robin. If both are valid, the granted one gets ready=1 and the pointer flips to the other. If only one is valid, it is granted and the pointer is unchanged.
  - ready is combinational from valid and state; a transfer occurs when valid&&ready.
  - A source holds valid, addr and data stable until accepted.
- Writes to x0:
  - Any write with addr 0 is accepted normally but produces reg_wr_en_o=0.
  - reg_wr_addr_o and reg_wr_data_o still update.
- Idle cycle (no transfer): reg_wr_en_o=0; addr and data hold their previous values.
- Scoreboard:
  - sb_set_en_i with a non-zero addr sets busy[addr] at the next edge.
  - An LSU/MDU transfer with a non-zero addr clears busy[addr] one cycle after reg_wr_en_o is high for it, so the register file already holds the value.
  - ALU writes never touch the scoreboard.
  - A set and a clear of the same index on the same edge: set wins.
  - busy[0] is constant 0.
  - A set of an already-busy register keeps it busy; no count is kept.
- In-order delivery per source is guaranteed. No ordering is guaranteed between sources.

Optional Feature:
- Macro: WB_MDU_FIFO_EN.
- Defined:
  - MDU results enter a MDU_FIFO_DEPTH-entry FIFO.
  - md_ready_o = !full, independent of the ALU.
  - The FIFO head, not md_*_i, competes in the LSU/MDU round-robin.
  - Simultaneous push and pop when full is illegal, since ready=0. When empty, push and pop in the same cycle is not a pass-through: the head is seen the next cycle.
  - Pointers wrap modulo the depth. full and empty are derived from an extra pointer bit.
- Undefined: no FIFO; md_ready_o is the direct grant as above.

Decomposition:
- Shared package wb_pkg: XLEN and REG_AW constants, a source-select enum (SRC_ALU, SRC_LSU, SRC_MDU), and the wb_req struct {valid, addr, data}.
- Sub-module wb_result_fifo holds the synchronous FIFO, instantiated only under WB_MDU_FIFO_EN.
- Arbitration, scoreboard and output register stay in regfile_writeback.

Test Plan:
- Reset asserted mid-stream with busy_o=0x0000_0024 and a pending MDU result -> immediately busy_o=0 and reg_wr_en_o=0; after release, no stale write appears.
- ALU write x5=0xDEAD_BEEF and LSU write x6 valid in the same cycle -> x5 is written at N+1 and ld_ready_o=0 that cycle; x6=LSU data is written at N+2.
- LSU and MDU both continuously valid, no ALU -> writes alternate LSU, MDU, LSU, MDU starting with LSU after reset; no source starves.
- sb_set x7, then LSU returns x7=0x1234 -> busy_o[7]=1 until one cycle after reg_wr_en_o with addr 7; a set of x7 on the clearing edge leaves busy_o[7]=1.
- ALU write to x0 with data 0xFFFF_FFFF -> reg_wr_en_o stays 0; sb_set x0 leaves busy_o=0.
- With WB_MDU_FIFO_EN: ALU valid for 6 cycles while the MDU pushes 5 results -> md_ready_o drops after 4 accepted; the FIFO drains 4 results in order once the ALU idles, and the 5th is accepted on the first free slot.
